csr_access: RTL and testbench

CSR_ACCESS -- requirements
Module: csr_access

---
 rtl/cpu_params_pkg.sv | 19 +
 rtl/csr_access_if.sv | 46 ++++
 rtl/csr_rmw_alu.sv | 34 +++
 rtl/csr_access.sv | 131 +++++++++++++
 tb/tb_csr_access.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_params_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_params_pkg : shared CPU widths and the CSR operation encoding.
// Rev 1.0
// ---------------------------------------------------------------------------
package cpu_params_pkg;

  localparam int RSZ    = 32;
  localparam int CSR_AW = 12;

  typedef enum logic [1:0] {
    CSR_OP_RSVD = 2'b00,
    CSR_OP_RW   = 2'b01,
    CSR_OP_RS   = 2'b10,
    CSR_OP_RC   = 2'b11
  } csr_op_t;

endpackage
`default_nettype wire

// File: rtl/csr_access_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_access_if : request/response handshake plus CSR bank read/write side.
// Rev 1.0
// ---------------------------------------------------------------------------
interface csr_access_if #(
  parameter int SZ = 32,
  parameter int AW = 12
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [SZ-1:0] req_wdata;
  logic          req_rs1_zero;
  logic [1:0]    priv_in;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [SZ-1:0] rsp_rdata;
  logic          rsp_illegal;

  logic [AW-1:0] csr_rd_addr;
  logic [SZ-1:0] csr_rd_data;
  logic          csr_legal;
  logic [SZ-1:0] csr_wmask;

  logic          csr_wr_en;
  logic [AW-1:0] csr_wr_addr;
  logic [SZ-1:0] csr_nxt_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, req_rs1_zero, priv_in,
    input  rsp_ready, csr_rd_data, csr_legal, csr_wmask,
    output req_ready, rsp_valid, rsp_rdata, rsp_illegal,
    output csr_rd_addr, csr_wr_en, csr_wr_addr, csr_nxt_data
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, req_rs1_zero, priv_in,
    output rsp_ready, csr_rd_data, csr_legal, csr_wmask,
    input  req_ready, rsp_valid, rsp_rdata, rsp_illegal,
    input  csr_rd_addr, csr_wr_en, csr_wr_addr, csr_nxt_data
  );
endinterface
`default_nettype wire

// File: rtl/csr_rmw_alu.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_rmw_alu : read-modify-write value for RW/RS/RC with WARL mask merge.
// Rev 1.0
// ---------------------------------------------------------------------------
module csr_rmw_alu
  import cpu_params_pkg::*;
#(
  parameter int SZ = RSZ
) (
  input  csr_op_t       op,
  input  logic [SZ-1:0] old_val,
  input  logic [SZ-1:0] wdata,
  input  logic [SZ-1:0] wmask,
  output logic [SZ-1:0] nxt_data
);

  logic [SZ-1:0] new_val;

  always_comb begin
    new_val = old_val;
    case (op)
      CSR_OP_RW: new_val = wdata;
      CSR_OP_RS: new_val = old_val | wdata;
      CSR_OP_RC: new_val = old_val & ~wdata;
      default:   new_val = old_val;
    endcase
  end

  // Bits outside the write mask always keep their current contents.
  assign nxt_data = (old_val & ~wmask) | (new_val & wmask);

endmodule
`default_nettype wire

// File: rtl/csr_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// csr_access : CSR instruction sequencer (read, privilege check, RMW write, respond).
// Rev 1.0
// ---------------------------------------------------------------------------
module csr_access
  import cpu_params_pkg::*;
#(
  parameter int SZ = RSZ,
  parameter int AW = CSR_AW
) (
  input  logic        clk_in,
  input  logic        reset_n_in,
  input  logic        flush_in,
  csr_access_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RSP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  csr_op_t       op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [SZ-1:0] wdata_q, wdata_d;
  logic          rs1_zero_q, rs1_zero_d;
  logic [1:0]    priv_q, priv_d;
  logic [SZ-1:0] old_q, old_d;
  logic [SZ-1:0] wmask_q, wmask_d;
  logic [SZ-1:0] rdata_q, rdata_d;
  logic          illegal_q, illegal_d;

  logic          accept;
  logic          wr_req;
  logic          illegal_rd;
  logic [SZ-1:0] nxt_data;

  assign accept = bus.req_valid & bus.req_ready;
  assign wr_req = (op_q == CSR_OP_RW) ||
                  (((op_q == CSR_OP_RS) || (op_q == CSR_OP_RC)) && !rs1_zero_q);
  // addr[9:8] is the minimum privilege, addr[11:10]==11 marks a read-only CSR.
  assign illegal_rd = !bus.csr_legal || (op_q == CSR_OP_RSVD) ||
                      (addr_q[9:8] > priv_q) ||
                      (wr_req && (addr_q[11:10] == 2'b11));

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rs1_zero_d = rs1_zero_q;
    priv_d     = priv_q;
    old_d      = old_q;
    wmask_d    = wmask_q;
    rdata_d    = rdata_q;
    illegal_d  = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d       = csr_op_t'(bus.req_op);
          addr_d     = bus.req_addr;
          wdata_d    = bus.req_wdata;
          rs1_zero_d = bus.req_rs1_zero;
          priv_d     = bus.priv_in;
          state_d    = S_RD;
        end
      end
      S_RD: begin
        old_d     = bus.csr_rd_data;
        wmask_d   = bus.csr_wmask;
        illegal_d = illegal_rd;
        rdata_d   = illegal_rd ? '0 : bus.csr_rd_data;
        if (flush_in)                  state_d = S_IDLE;
        else if (!illegal_rd && wr_req) state_d = S_WR;
        else                           state_d = S_RSP;
      end
      // A flush here still lets the write land; only the response is dropped.
      S_WR:    state_d = flush_in ? S_IDLE : S_RSP;
      S_RSP:   if (flush_in || bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q    <= S_IDLE;
      op_q       <= CSR_OP_RSVD;
      addr_q     <= '0;
      wdata_q    <= '0;
      rs1_zero_q <= 1'b0;
      priv_q     <= 2'b00;
      old_q      <= '0;
      wmask_q    <= '0;
      rdata_q    <= '0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rs1_zero_q <= rs1_zero_d;
      priv_q     <= priv_d;
      old_q      <= old_d;
      wmask_q    <= wmask_d;
      rdata_q    <= rdata_d;
      illegal_q  <= illegal_d;
    end
  end

  csr_rmw_alu #(.SZ(SZ)) u_rmw_alu (
    .op       (op_q),
    .old_val  (old_q),
    .wdata    (wdata_q),
    .wmask    (wmask_q),
    .nxt_data (nxt_data)
  );

  assign bus.req_ready    = reset_n_in && (state_q == S_IDLE) && !flush_in;
  assign bus.csr_rd_addr  = addr_q;
  assign bus.csr_wr_en    = (state_q == S_WR);
  assign bus.csr_wr_addr  = addr_q;
  assign bus.csr_nxt_data = nxt_data;
  assign bus.rsp_valid    = (state_q == S_RSP);
  assign bus.rsp_rdata    = (state_q == S_RSP) ? rdata_q : '0;
  assign bus.rsp_illegal  = (state_q == S_RSP) && illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_csr_access.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_csr_access : directed vectors with a response/write scoreboard.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_csr_access;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int wr_cnt = 0;

  logic [32:0] rsp_q[$];   // {illegal, rdata}
  logic [43:0] wr_q[$];    // {addr, nxt}

  always #5 clk = ~clk;

  csr_access_if #(.SZ(32), .AW(12)) bus ();

  csr_access #(.SZ(32), .AW(12)) dut (
    .clk_in     (clk),
    .reset_n_in (rst_n),
    .flush_in   (flush),
    .bus        (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s: event seen, none expected", name);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write or a response.
  initial begin
    logic        wr_prev;
    logic [43:0] ew;
    logic [32:0] er;
    wr_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wr_prev = 1'b0;
      end else begin
        if (bus.csr_wr_en) begin
          chk("wr_pulse_len", {31'd0, wr_prev}, 32'd0);
          if (wr_q.size() == 0) fail("wr_unexpected");
          else begin
            ew = wr_q.pop_front();
            chk("wr_addr", {20'd0, bus.csr_wr_addr}, {20'd0, ew[43:32]});
            chk("wr_nxt", bus.csr_nxt_data, ew[31:0]);
          end
          wr_cnt++;
        end
        wr_prev = bus.csr_wr_en;
        if (bus.rsp_valid && rsp_q.size() == 0) fail("rsp_unexpected");
        else if (bus.rsp_valid && bus.rsp_ready) begin
          er = rsp_q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, er[31:0]);
          chk("rsp_illegal", {31'd0, bus.rsp_illegal}, {31'd0, er[32]});
        end
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                      input logic rz, input logic [1:0] pv, input logic [31:0] old,
                      input logic lg, input logic [31:0] wm);
    int t;
    bus.csr_rd_data  = old;
    bus.csr_legal    = lg;
    bus.csr_wmask    = wm;
    bus.req_op       = op;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_rs1_zero = rz;
    bus.priv_in      = pv;
    bus.req_valid    = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!bus.req_ready && t < 20);
    if (!bus.req_ready) $display("FAIL accept_timeout: got no req_ready, expected 1");
    if (!bus.req_ready) n_err++;
    n_vec++;
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] wd,
                       input logic rz, input logic [1:0] pv, input logic [31:0] old,
                       input logic lg, input logic [31:0] wm, input logic ew,
                       input logic [31:0] en, input logic [31:0] er, input logic ei,
                       input int el, input bit hold);
    int lat;
    logic [31:0] held;
    bus.rsp_ready = !hold;
    rsp_q.push_back({ei, er});
    if (ew) wr_q.push_back({addr, en});
    send(op, addr, wd, rz, pv, old, lg, wm);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!bus.rsp_valid && lat < 10);
    chk("latency", 32'(lat), 32'(el));
    if (hold) begin
      held = bus.rsp_rdata;
      repeat (5) begin
        @(negedge clk);
        chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
        chk("hold_rdata", bus.rsp_rdata, held);
        chk("hold_req_ready", {31'd0, bus.req_ready}, 32'd0);
      end
      @(posedge clk);
      #1 bus.rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
    bus.req_rs1_zero = 1'b0; bus.priv_in = 2'b00; bus.rsp_ready = 1'b1;
    bus.csr_rd_data = '0; bus.csr_legal = 1'b0; bus.csr_wmask = '0;

    @(negedge clk);
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_wr_en", {31'd0, bus.csr_wr_en}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_illegal", {31'd0, bus.rsp_illegal}, 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk); #1;

    //     op     addr     wdata         rz pv old           lg wmask         ew nxt           rdata         il lat hold
    issue(2'b10, 12'h300, 32'h00000080, 0, 3, 32'h00000008, 1, 32'h00001888, 1, 32'h00000088, 32'h00000008, 0, 3, 0);
    issue(2'b01, 12'hC00, 32'h00001234, 0, 3, 32'h0000DEAD, 1, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        1, 2, 0);
    issue(2'b11, 12'h341, 32'hFFFFFFFF, 1, 3, 32'h80000004, 1, 32'hFFFFFFFF, 0, 32'h0,        32'h80000004, 0, 2, 0);
    issue(2'b01, 12'h300, 32'h00000005, 0, 0, 32'h00000077, 1, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        1, 2, 0);
    issue(2'b01, 12'h300, 32'h00000005, 0, 3, 32'h00000077, 0, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        1, 2, 0);
    issue(2'b01, 12'h340, 32'hAAAA5555, 0, 3, 32'h11110000, 1, 32'hFFFFFFFF, 1, 32'hAAAA5555, 32'h11110000, 0, 3, 0);
    issue(2'b11, 12'h305, 32'h0F0F0F0F, 0, 3, 32'hFFFF00FF, 1, 32'hFF00FF00, 1, 32'hF0FF00FF, 32'hFFFF00FF, 0, 3, 0);
    issue(2'b00, 12'h300, 32'h00000000, 0, 3, 32'h00000001, 1, 32'hFFFFFFFF, 0, 32'h0,        32'h0,        1, 2, 0);
    issue(2'b10, 12'hC00, 32'h00000001, 1, 3, 32'h000000AB, 1, 32'hFFFFFFFF, 0, 32'h0,        32'h000000AB, 0, 2, 0);
    issue(2'b10, 12'h200, 32'h00000000, 1, 2, 32'h00000042, 1, 32'hFFFFFFFF, 0, 32'h0,        32'h00000042, 0, 2, 0);
    issue(2'b10, 12'hF11, 32'h00000000, 1, 3, 32'h5A5A5A5A, 1, 32'hFFFFFFFF, 0, 32'h0,        32'h5A5A5A5A, 0, 2, 1);

    // Flush while idle blocks acceptance.
    flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_ready", {31'd0, bus.req_ready}, 32'd0);
    #1 flush = 1'b0;
    @(posedge clk); #1;

    // Flush in RD: nothing written, nothing returned.
    w0 = wr_cnt;
    send(2'b01, 12'h340, 32'h00000001, 0, 3, 32'h0, 1, 32'hFFFFFFFF);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_rd_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("flush_rd_valid", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("flush_rd_wrcnt", 32'(wr_cnt - w0), 32'd0);
    @(posedge clk); #1;

    // Flush in WR: the write completes, the response is dropped.
    w0 = wr_cnt;
    wr_q.push_back({12'h340, 32'h000000F0});
    send(2'b01, 12'h340, 32'h000000F0, 0, 3, 32'h0, 1, 32'hFFFFFFFF);
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_wr_ready", {31'd0, bus.req_ready}, 32'd1);
    chk("flush_wr_valid", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    chk("flush_wr_wrcnt", 32'(wr_cnt - w0), 32'd1);
    @(posedge clk); #1;

    // Reset asserted in WR drops the write strobe immediately.
    w0 = wr_cnt;
    send(2'b01, 12'h340, 32'h00000003, 0, 3, 32'h0, 1, 32'hFFFFFFFF);
    @(posedge clk); #1;
    chk("wr_state_reached", {31'd0, bus.csr_wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_en_drop", {31'd0, bus.csr_wr_en}, 32'd0);
    chk("rst_mid_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_mid_valid", {31'd0, bus.rsp_valid}, 32'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_mid_recover", {31'd0, bus.req_ready}, 32'd1);
    chk("rst_mid_wrcnt", 32'(wr_cnt - w0), 32'd0);
    @(posedge clk); #1;

    issue(2'b10, 12'h300, 32'h00000080, 0, 3, 32'h00000008, 1, 32'h00001888, 1, 32'h00000088, 32'h00000008, 0, 3, 0);

    repeat (3) @(negedge clk);
    chk("rsp_q_empty", 32'(rsp_q.size()), 32'd0);
    chk("wr_q_empty", 32'(wr_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
